// File: rtl/fpmulr8.sv
// fpmulr8 - iterative radix-8 unsigned multiply-accumulate, p = a*b + c.
// Retires three multiplier bits per enabled clock. It is used to rebuild a
// dividend from a divider's quotient, divisor and remainder.
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset (overrides ce and ld)
//   ce    in   clock enable; all registers hold when low
//   ld    in   start strobe; accepted on an enabled edge, aborts any run
//   a     in   WID     multiplicand, unsigned
//   b     in   WID     multiplier, unsigned
//   c     in   2*WID   addend, unsigned
//   p     out  2*WID   (a*b+c) mod 2^(2*WID), written only on completion
//   ovf   out  1       carry out of bit 2*WID-1, written with p
//   done  out  1       result valid until the next accepted ld
//
// state | meaning
// IDLE  | waiting for ld; p/ovf/done hold
// MUL   | one radix-8 digit step per enabled edge
// FIN   | publish acc to p/ovf, raise done
module fpmulr8 #(
  parameter int WID = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               ld,
  input  logic [WID-1:0]     a,
  input  logic [WID-1:0]     b,
  input  logic [2*WID-1:0]   c,
  output logic [2*WID-1:0]   p,
  output logic               ovf,
  output logic               done
);

  localparam int N  = (WID + 2) / 3;
  localparam int AW = 2 * WID + 1;
  localparam int MW = 3 * N;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [AW-1:0]     mcand_q, mcand_d;
  logic [MW-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*WID-1:0]  p_q, p_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic              do_load, do_step, do_fin, last_step;
  logic [2:0]        dig;
  logic [AW-1:0]     pp;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign last_step = (cnt_q == CW'(N - 1));

  // Next-state logic; ld takes priority in every state
  always_comb begin
    state_d = state_q;
    if (ce) begin
      if (ld) begin
        state_d = MUL;
      end else begin
        case (state_q)
          MUL:     if (last_step) state_d = FIN;
          FIN:     state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Output / datapath control
  always_comb begin
    do_load = ce & ld;
    do_step = ce & ~ld & (state_q == MUL);
    do_fin  = ce & ~ld & (state_q == FIN);
  end

  // Digit partial product built from shifted copies, no multiplier primitive
  always_comb begin
    dig = mplier_q[2:0];
    pp  = (dig[0] ? mcand_q        : {AW{1'b0}})
        + (dig[1] ? (mcand_q << 1) : {AW{1'b0}})
        + (dig[2] ? (mcand_q << 2) : {AW{1'b0}});
  end

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    ovf_d    = ovf_q;
    done_d   = done_q;
    if (do_load) begin
      acc_d    = {1'b0, c};
      mcand_d  = AW'(a);
      mplier_d = MW'(b);
      cnt_d    = '0;
      done_d   = 1'b0;
    end else if (do_step) begin
      acc_d    = acc_q + pp;
      mcand_d  = mcand_q << 3;
      mplier_d = mplier_q >> 3;
      cnt_d    = CW'(cnt_q + 1'b1);
    end else if (do_fin) begin
      p_d      = acc_q[2*WID-1:0];
      ovf_d    = acc_q[2*WID];
      done_d   = 1'b1;
    end
  end

  assign p    = p_q;
  assign ovf  = ovf_q;
  assign done = done_q;

endmodule

// File: tb/tb_fpmulr8.sv
module tb_fpmulr8;

  logic        clk = 1'b0;
  logic        rst, ce;
  logic        ld;
  logic [15:0] a, b;
  logic [31:0] c;
  logic [31:0] p;
  logic        ovf, done;

  logic        ld8;
  logic [7:0]  a8, b8;
  logic [15:0] c8;
  logic [15:0] p8;
  logic        ovf8, done8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fpmulr8 #(.WID(16)) dut (
    .clk(clk), .rst(rst), .ce(ce), .ld(ld),
    .a(a), .b(b), .c(c), .p(p), .ovf(ovf), .done(done)
  );

  fpmulr8 #(.WID(8)) dut8 (
    .clk(clk), .rst(rst), .ce(ce), .ld(ld8),
    .a(a8), .b(b8), .c(c8), .p(p8), .ovf(ovf8), .done(done8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one ld on the 16-bit unit and count enabled edges until done
  task automatic run16(input logic [15:0] ai, input logic [15:0] bi,
                       input logic [31:0] ci, input string tag, output int n);
    a = ai; b = bi; c = ci; ld = 1'b1;
    step();
    ld = 1'b0;
    chk({tag, "_done_drop"}, 64'(done), 64'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (done) break;
    end
  endtask

  task automatic run8(input logic [7:0] ai, input logic [7:0] bi,
                      input logic [15:0] ci, output int n);
    a8 = ai; b8 = bi; c8 = ci; ld8 = 1'b1;
    step();
    ld8 = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (done8) break;
    end
  endtask

  initial begin
    int  n;
    int  rises, rise_edge;
    bit  seen15, prev_done, any_done;

    rst = 1'b1; ce = 1'b1; ld = 1'b0; a = '0; b = '0; c = '0;
    ld8 = 1'b0; a8 = '0; b8 = '0; c8 = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_p",    64'(p),     64'd0);
    chk("rst_ovf",  64'(ovf),   64'd0);
    chk("rst_done", 64'(done),  64'd0);
    chk("rst_p8",   64'(p8),    64'd0);
    chk("rst_done8",64'(done8), 64'd0);

    // 101*75+79 = 7654
    run16(16'd101, 16'd75, 32'd79, "rt", n);
    chk("rt_lat", 64'(n),   64'd7);
    chk("rt_p",   64'(p),   64'h0000_1DE6);
    chk("rt_ovf", 64'(ovf), 64'd0);

    // Full-scale square, then back-to-back with full-scale addend
    run16(16'hFFFF, 16'hFFFF, 32'h0, "sq", n);
    chk("sq_lat", 64'(n),   64'd7);
    chk("sq_p",   64'(p),   64'hFFFE_0001);
    chk("sq_ovf", 64'(ovf), 64'd0);
    run16(16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF, "mx", n);
    chk("mx_lat", 64'(n),   64'd7);
    chk("mx_p",   64'(p),   64'hFFFE_0000);
    chk("mx_ovf", 64'(ovf), 64'd1);

    // Abort: 3*5 started, reloaded with 7*9+1 on the third MUL edge
    a = 16'd3; b = 16'd5; c = 32'd0; ld = 1'b1;
    step();
    ld = 1'b0;
    step(); step();
    a = 16'd7; b = 16'd9; c = 32'd1; ld = 1'b1;
    step();
    ld = 1'b0;
    rises = 0; rise_edge = 0; seen15 = 1'b0; prev_done = done;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (p == 32'd15) seen15 = 1'b1;
      if (done && !prev_done) begin
        rises++;
        rise_edge = i;
      end
      prev_done = done;
    end
    chk("ab_rises", 64'(rises),     64'd1);
    chk("ab_lat",   64'(rise_edge), 64'd7);
    chk("ab_p",     64'(p),         64'd64);
    chk("ab_no15",  64'(seen15),    64'd0);

    // Clock-enable stall of 4 cycles mid-MUL
    a = 16'd1234; b = 16'd4321; c = 32'd0; ld = 1'b1;
    step();
    ld = 1'b0;
    step(); step();
    ce = 1'b0;
    step(); step(); step(); step();
    chk("ce_hold_done", 64'(done), 64'd0);
    ce = 1'b1;
    n = 6;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (done) break;
    end
    chk("ce_lat", 64'(n),   64'd11);
    chk("ce_p",   64'(p),   64'd5332114);
    chk("ce_ovf", 64'(ovf), 64'd0);

    // Reset during the second MUL step
    a = 16'd3; b = 16'd5; c = 32'd0; ld = 1'b1;
    step();
    ld = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_p",    64'(p),    64'd0);
    chk("mr_ovf",  64'(ovf),  64'd0);
    chk("mr_done", 64'(done), 64'd0);
    any_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) any_done = 1'b1;
    end
    chk("mr_no_done", 64'(any_done), 64'd0);

    // 8-bit instance: 255*129+256 = 33151, then 255*255+65535 = 0x1FE00
    run8(8'hFF, 8'h81, 16'h0100, n);
    chk("w8_lat", 64'(n),    64'd4);
    chk("w8_p",   64'(p8),   64'h817F);
    chk("w8_ovf", 64'(ovf8), 64'd0);
    run8(8'hFF, 8'hFF, 16'hFFFF, n);
    chk("w8m_lat", 64'(n),    64'd4);
    chk("w8m_p",   64'(p8),   64'hFE00);
    chk("w8m_ovf", 64'(ovf8), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
